// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR sequencing controller.
// Holds the state encoding, the default tap count and the tap-index width helper.
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CLEAR = 3'd2,
        MAC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_NUM_TAPS = 4;

    // Never returns zero, so a tap index always has at least one bit.
    function automatic int tap_idx_w(input int num_taps);
        return (num_taps <= 2) ? 1 : $clog2(num_taps);
    endfunction

endpackage

// File: rtl/fir_ctrl_if.sv
// Control bundle between the SPI front end, the FIR datapath and the sequencing controller.
// master drives requests and acks; slave is the controller.
interface fir_ctrl_if
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int IDX_W    = tap_idx_w(NUM_TAPS)
);
    logic                sample_valid;
    logic                coeff_valid;
    logic [IDX_W-1:0]    coeff_addr;
    logic                result_ack;
    logic                clear_err;
    logic                shift_en;
    logic [NUM_TAPS-1:0] coeff_we;
    logic [IDX_W-1:0]    tap_sel;
    logic                acc_clear;
    logic                acc_en;
    logic                result_valid;
    logic                busy;
    logic                overrun;
    logic                cfg_err;

    modport master (
        output sample_valid, coeff_valid, coeff_addr, result_ack, clear_err,
        input  shift_en, coeff_we, tap_sel, acc_clear, acc_en, result_valid,
               busy, overrun, cfg_err
    );

    modport slave (
        input  sample_valid, coeff_valid, coeff_addr, result_ack, clear_err,
        output shift_en, coeff_we, tap_sel, acc_clear, acc_en, result_valid,
               busy, overrun, cfg_err
    );
endinterface

// File: rtl/fir_ctrl_tap.sv
// Tap index counter: synchronous clear, count enable, returns to 0 after NUM_TAPS-1.
// rollover flags the last tap so the controller can leave MAC on the same edge.
module tap_counter #(
    parameter int NUM_TAPS = 4,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [IDX_W-1:0] count,
    output logic             rollover
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TAPS - 1);

    assign rollover = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= rollover ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencing controller: shifts a sample, clears the accumulator, walks every tap, then
// holds result_valid until acked. Produces control only; sticky error flags track dropped requests.
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int IDX_W    = tap_idx_w(NUM_TAPS)
) (
    input  logic     clk,
    input  logic     reset,
    fir_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_SHIFT = SHIFT;
    localparam logic [2:0] S_CLEAR = CLEAR;
    localparam logic [2:0] S_MAC   = MAC;
    localparam logic [2:0] S_DONE  = DONE;

    localparam logic [IDX_W:0] TAP_LIMIT = (IDX_W + 1)'(NUM_TAPS);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [IDX_W-1:0]    tap_cnt;
    logic                rollover;
    logic [NUM_TAPS-1:0] coeff_we_q;
    logic [NUM_TAPS-1:0] coeff_we_nxt;
    logic                overrun_q;
    logic                cfg_err_q;
    logic                idle;
    logic                addr_ok;
    logic                ovr_set;
    logic                cfg_set;

    tap_counter #(
        .NUM_TAPS (NUM_TAPS),
        .IDX_W    (IDX_W)
    ) u_tap_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == S_CLEAR),
        .en       (state == S_MAC),
        .count    (tap_cnt),
        .rollover (rollover)
    );

    assign idle    = (state == S_IDLE);
    assign addr_ok = ({1'b0, bus.coeff_addr} < TAP_LIMIT);

    // A sample always wins over a coefficient write offered in the same cycle.
    assign ovr_set      = bus.sample_valid && !idle;
    assign cfg_set      = bus.coeff_valid && (!idle || bus.sample_valid || !addr_ok);
    assign coeff_we_nxt = (bus.coeff_valid && idle && !bus.sample_valid && addr_ok)
                        ? (NUM_TAPS'(1) << bus.coeff_addr) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.sample_valid) state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_MAC;
            S_MAC:   if (rollover) state_nxt = S_DONE;
            S_DONE:  if (bus.result_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            coeff_we_q <= '0;
            overrun_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            coeff_we_q <= coeff_we_nxt;
            overrun_q  <= ovr_set || (overrun_q && !bus.clear_err);
            cfg_err_q  <= cfg_set || (cfg_err_q && !bus.clear_err);
        end
    end

    assign bus.shift_en     = (state == S_SHIFT);
    assign bus.acc_clear    = (state == S_CLEAR);
    assign bus.acc_en       = (state == S_MAC);
    assign bus.result_valid = (state == S_DONE);
    assign bus.busy         = !idle;
    assign bus.tap_sel      = (state == S_MAC) ? tap_cnt : '0;
    assign bus.coeff_we     = coeff_we_q;
    assign bus.overrun      = overrun_q;
    assign bus.cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with a scoreboard of expected tap selects and coefficient strobes.
module tb_fir_ctrl;
    localparam int NT = 4;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   exp_tap[$];
    int   exp_we[$];

    always #5 clk = ~clk;

    fir_ctrl_if #(.NUM_TAPS(NT), .IDX_W(IW)) bus ();

    fir_ctrl #(.NUM_TAPS(NT), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return {18'd0, bus.shift_en, bus.acc_clear, bus.acc_en, bus.result_valid, bus.busy,
                bus.overrun, bus.cfg_err, bus.coeff_we, bus.tap_sel};
    endfunction

    task automatic start_sample();
        bus.sample_valid = 1'b1;
        for (int i = 0; i < NT; i++) exp_tap.push_back(i);
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        while (!bus.result_valid && n < 50) begin
            tick();
            n++;
        end
        chk("result_wait", 32'(bus.result_valid), 32'd1);
    endtask

    task automatic coeff_write(input int addr, input bit ok);
        bus.coeff_valid = 1'b1;
        bus.coeff_addr  = IW'(addr);
        if (ok) exp_we.push_back(1 << addr);
        tick();
        bus.coeff_valid = 1'b0;
        chk("coeff_we_pulse", 32'(bus.coeff_we), ok ? 32'(1 << addr) : 32'd0);
        chk("coeff_cfg_err", 32'(bus.cfg_err), ok ? 32'd0 : 32'd1);
        tick();
        chk("coeff_we_once", 32'(bus.coeff_we), 32'd0);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
    endtask

    // Scoreboard side: every observed MAC step and coefficient strobe must match a queued entry.
    always @(posedge clk) begin
        #2;
        chk("excl_shift_we", 32'(bus.shift_en && (bus.coeff_we != '0)), 32'd0);
        chk("excl_clr_acc", 32'(bus.acc_clear && bus.acc_en), 32'd0);
        if (bus.acc_en) begin
            if (exp_tap.size() == 0) chk("unexpected_acc_en", 32'(bus.acc_en), 32'd0);
            else chk("sb_tap_sel", 32'(bus.tap_sel), 32'(exp_tap.pop_front()));
        end
        if (bus.coeff_we != '0) begin
            if (exp_we.size() == 0) chk("unexpected_coeff_we", 32'(bus.coeff_we), 32'd0);
            else chk("sb_coeff_we", 32'(bus.coeff_we), 32'(exp_we.pop_front()));
        end
    end

    initial begin
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.coeff_valid  = 1'b0;
        bus.coeff_addr   = '0;
        bus.result_ack   = 1'b0;
        bus.clear_err    = 1'b0;
        repeat (3) tick();
        chk("reset_held", all_out(), 32'd0);
        reset = 1'b0;
        tick();
        chk("after_reset", all_out(), 32'd0);

        // Nominal sequence with ack tied high.
        bus.result_ack = 1'b1;
        repeat (4) tick();
        start_sample();
        chk("shift_cycle", {bus.shift_en, bus.busy, bus.acc_clear}, 3'b110);
        tick();
        chk("clear_cycle", {bus.acc_clear, bus.acc_en, bus.shift_en}, 3'b100);
        for (int i = 0; i < NT; i++) begin
            tick();
            chk("mac_cycle", {bus.acc_en, bus.acc_clear, 1'b0, bus.tap_sel}, {3'b100, IW'(i)});
        end
        tick();
        chk("done_cycle", {bus.result_valid, bus.busy, bus.acc_en}, 3'b110);
        tick();
        chk("idle_after_done", all_out(), 32'd0);

        // Coefficient writes: in-range boundaries and out-of-range addresses.
        bus.result_ack = 1'b0;
        coeff_write(2, 1'b1);
        coeff_write(5, 1'b0);
        coeff_write(0, 1'b1);
        coeff_write(3, 1'b1);
        coeff_write(4, 1'b0);

        // Overrun during MAC and during DONE with ack.
        bus.result_ack = 1'b1;
        start_sample();
        repeat (3) tick();
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        chk("ovr_mac", {bus.overrun, bus.shift_en, 1'b0, bus.tap_sel}, {3'b100, IW'(2)});
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("ovr_cleared", {bus.overrun, 1'b0, bus.tap_sel}, {2'b00, IW'(3)});
        wait_result();
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        chk("ovr_done_ack", {bus.overrun, bus.busy, bus.shift_en}, 3'b100);
        tick();
        chk("no_extra_shift", {bus.busy, bus.shift_en}, 2'b00);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("ovr_clear2", 32'(bus.overrun), 32'd0);

        // Ack withheld in DONE; a busy coefficient write is dropped.
        bus.result_ack = 1'b0;
        start_sample();
        wait_result();
        for (int i = 0; i < 20; i++) begin
            bus.coeff_valid = (i == 5);
            bus.coeff_addr  = IW'(1);
            tick();
            chk("done_hold", {bus.result_valid, bus.busy}, 2'b11);
        end
        bus.coeff_valid = 1'b0;
        chk("busy_cfg_err", {bus.cfg_err, 1'b0, bus.coeff_we}, 6'b100000);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        chk("ack_to_idle", {bus.busy, bus.result_valid}, 2'b00);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        start_sample();
        chk("second_shift", 32'(bus.shift_en), 32'd1);
        wait_result();
        chk("second_taps_done", 32'(exp_tap.size()), 32'd0);
        bus.result_ack = 1'b1;
        tick();

        // Simultaneous sample and coefficient; set beats clear.
        bus.coeff_valid = 1'b1;
        bus.coeff_addr  = IW'(1);
        start_sample();
        bus.coeff_valid = 1'b0;
        chk("sim_req", {bus.shift_en, bus.cfg_err, 1'b0, bus.coeff_we}, 7'b1100000);
        wait_result();
        tick();
        bus.clear_err   = 1'b1;
        bus.coeff_valid = 1'b1;
        bus.coeff_addr  = IW'(6);
        tick();
        bus.clear_err   = 1'b0;
        bus.coeff_valid = 1'b0;
        chk("set_beats_clear", 32'(bus.cfg_err), 32'd1);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("cfg_cleared", 32'(bus.cfg_err), 32'd0);

        // Reset mid-MAC abandons the sequence.
        start_sample();
        repeat (4) tick();
        chk("mid_mac_tap", {bus.acc_en, 1'b0, bus.tap_sel}, {2'b10, IW'(2)});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_tap.delete();
        chk("reset_mid_mac", all_out(), 32'd0);
        tick();
        chk("idle_after_reset", all_out(), 32'd0);

        chk("tap_q_empty", 32'(exp_tap.size()), 32'd0);
        chk("we_q_empty", 32'(exp_we.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
